// File: rtl/blake2_pkg.sv
// blake2_pkg: shared FSM encoding, block sizing helpers and parameter legality check
// Contents: state_t (packer states), blk_bytes/idx_bits (sizing from W), in_bytes_ok (W/IN_BYTES legality)
package blake2_pkg;
    typedef enum logic [2:0] {IDLE, FILL, EMIT, WAIT_H, OUT} state_t;
    function automatic int blk_bytes(int w);
        return 2 * w;
    endfunction
    // Index must reach BB itself, hence one bit more than addressing BB bytes
    function automatic int idx_bits(int w);
        return $clog2(2 * w) + 1;
    endfunction
    function automatic bit in_bytes_ok(int w, int ib);
        return (w == 32 || w == 64) && (ib inside {1, 2, 4, 8}) && ((2 * w) % ib == 0);
    endfunction
endpackage

// File: rtl/blake2_stream_pack_if.sv
// blake2_stream_pack_if: byte-stream in, message block out, chaining value in, digest bytes out
// Ports: start/out_len (message control), s_* (input beats), blk_* (block to core),
//        h_in/h_valid (final chaining value), d_* (digest byte stream)
// Modports: slave = packer view, master = source/core/sink view
interface blake2_stream_pack_if #(
    parameter int W        = 32,
    parameter int IN_BYTES = 4
);
    logic                        start;
    logic [$clog2(W):0]          out_len;
    logic [8*IN_BYTES-1:0]       s_data;
    logic [$clog2(IN_BYTES):0]   s_nbytes;
    logic                        s_last;
    logic                        s_valid;
    logic                        s_ready;
    logic [16*W-1:0]             blk_m;
    logic [2*W-1:0]              blk_t;
    logic                        blk_f;
    logic                        blk_valid;
    logic                        blk_ready;
    logic [8*W-1:0]              h_in;
    logic                        h_valid;
    logic [7:0]                  d_data;
    logic                        d_valid;
    logic                        d_ready;
    logic                        d_last;
    modport slave (
        input  start, out_len, s_data, s_nbytes, s_last, s_valid, blk_ready, h_in, h_valid, d_ready,
        output s_ready, blk_m, blk_t, blk_f, blk_valid, d_data, d_valid, d_last
    );
    modport master (
        output start, out_len, s_data, s_nbytes, s_last, s_valid, blk_ready, h_in, h_valid, d_ready,
        input  s_ready, blk_m, blk_t, blk_f, blk_valid, d_data, d_valid, d_last
    );
endinterface

// File: rtl/blake2_digest_ser.sv
// blake2_digest_ser: serializes the low i_len bytes of a chaining value under ready/valid
// Ports: clk, rst (sync, active-high), i_clr (abort), i_load/i_len/i_h (capture digest),
//        i_ready (sink), o_data/o_valid/o_last (byte stream), o_done (last byte handshake)
module blake2_digest_ser #(
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [$clog2(W):0]   i_len,
    input  logic [8*W-1:0]       i_h,
    input  logic                 i_ready,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_done
);
    localparam int LW = $clog2(W) + 1;
    logic [8*W-1:0] r_h;
    logic [LW-1:0]  r_cnt;
    logic [7:0]     r_data;
    logic           r_valid;
    logic           r_last;
    logic           w_hs;
    assign w_hs = r_valid & i_ready;
    // r_h shifts right so its byte 1 is always the next byte to present; r_cnt counts bytes remaining
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_h     <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_h     <= i_h;
            r_cnt   <= i_len;
            r_data  <= i_h[7:0];
            r_valid <= 1'b1;
            r_last  <= i_len == LW'(1);
        end else if (w_hs) begin
            r_h     <= r_h >> 8;
            r_cnt   <= r_cnt - LW'(1);
            r_data  <= r_h[15:8];
            r_valid <= !r_last;
            r_last  <= r_cnt == LW'(2);
        end
    end
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_done  = w_hs & r_last;
endmodule

// File: rtl/blake2_stream_pack.sv
// blake2_stream_pack: packs byte beats into BLAKE2 message blocks and streams digest bytes back
// Ports: clk, rst (sync, active-high), bus (blake2_stream_pack_if.slave: start/out_len,
//        s_* input beats, blk_* block to core, h_in/h_valid chaining value, d_* digest bytes)
module blake2_stream_pack
    import blake2_pkg::*;
#(
    parameter int W        = 32,
    parameter int IN_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    blake2_stream_pack_if.slave   bus
);
    localparam int BB = blk_bytes(W);
    localparam int IW = idx_bits(W);
    localparam int NB = 8 * IN_BYTES;
    localparam int LW = $clog2(W) + 1;
    localparam int TW = 2 * W;

    if (!in_bytes_ok(W, IN_BYTES)) begin : g_bad_params
        $error("blake2_stream_pack: W must be 32/64 and IN_BYTES a power of two 1..8 dividing 2*W");
    end

    state_t                   r_state;
    logic [8*BB-1:0]          r_buf;
    logic [IW-1:0]            r_idx;
    logic [TW-1:0]            r_t;
    logic                     r_f;
    logic                     r_s_ready;
    logic                     r_blk_valid;
    logic [LW-1:0]            r_len;
    logic [NB-1:0]            w_beat;
    logic [IW-1:0]            w_idx_nxt;
    logic [$clog2(8*BB)-1:0]  w_base;
    logic [LW-1:0]            w_len_eff;
    logic                     w_acc;
    logic                     w_load;
    logic                     w_done;

    assign w_acc     = r_s_ready & bus.s_valid;
    assign w_idx_nxt = r_idx + IW'(bus.s_nbytes);
    // Beats are full until the last one, so idx is always beat-aligned and below BB while filling
    assign w_base    = {r_idx[IW-2:0], 3'b000};
    assign w_len_eff = (bus.out_len == '0 || bus.out_len > LW'(W)) ? LW'(W) : bus.out_len;
    assign w_load    = (r_state == WAIT_H) & bus.h_valid & !bus.start;

    // Bytes past s_nbytes are forced to zero so a short final beat leaves zero padding
    always_comb begin
        w_beat = '0;
        for (int k = 0; k < IN_BYTES; k++)
            w_beat[8*k +: 8] = (k < int'(bus.s_nbytes)) ? bus.s_data[8*k +: 8] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_t         <= '0;
            r_f         <= 1'b0;
            r_s_ready   <= 1'b0;
            r_blk_valid <= 1'b0;
            r_len       <= '0;
        end else if (bus.start) begin
            r_state     <= FILL;
            r_buf       <= '0;
            r_idx       <= '0;
            r_t         <= '0;
            r_f         <= 1'b0;
            r_s_ready   <= 1'b1;
            r_blk_valid <= 1'b0;
            r_len       <= w_len_eff;
        end else begin
            case (r_state)
                FILL: if (w_acc) begin
                    r_buf[w_base +: NB] <= w_beat;
                    r_idx               <= w_idx_nxt;
                    r_t                 <= r_t + TW'(bus.s_nbytes);
                    // A full block is held back as non-final unless this beat also ends the message,
                    // so a k*BB-byte message never needs a trailing empty block
                    if (w_idx_nxt == IW'(BB) || bus.s_last) begin
                        r_state     <= EMIT;
                        r_f         <= bus.s_last;
                        r_s_ready   <= 1'b0;
                        r_blk_valid <= 1'b1;
                    end
                end
                EMIT: if (bus.blk_ready) begin
                    r_buf       <= '0;
                    r_idx       <= '0;
                    r_f         <= 1'b0;
                    r_blk_valid <= 1'b0;
                    r_s_ready   <= !r_f;
                    r_state     <= r_f ? WAIT_H : FILL;
                end
                WAIT_H: if (bus.h_valid) r_state <= OUT;
                OUT:    if (w_done) r_state <= IDLE;
                default: ;
            endcase
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.blk_m     = r_buf;
    assign bus.blk_t     = r_t;
    assign bus.blk_f     = r_f;
    assign bus.blk_valid = r_blk_valid;

    blake2_digest_ser #(.W(W)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.start),
        .i_load  (w_load),
        .i_len   (r_len),
        .i_h     (bus.h_in),
        .i_ready (bus.d_ready),
        .o_data  (bus.d_data),
        .o_valid (bus.d_valid),
        .o_last  (bus.d_last),
        .o_done  (w_done)
    );
endmodule

// File: tb/tb_blake2_stream_pack.sv
// tb_blake2_stream_pack: table, hand-written and random checks of blake2_stream_pack against a message-level model
module tb_blake2_stream_pack;
    localparam int W  = 32;
    localparam int IB = 4;
    localparam int BB = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [8*BB-1:0] m; logic [2*W-1:0] t; logic f; } blk_rec_t;
    typedef struct { int len; int out_len; int exp_nblk; int exp_t; int exp_dlen; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blake2_stream_pack_if #(.W(W), .IN_BYTES(IB)) bus();
    blake2_stream_pack #(.W(W), .IN_BYTES(IB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int       n_cmp = 0;
    int       n_bad = 0;
    blk_rec_t blk_q[$];
    logic [8:0] dig_q[$];
    int       bp_mode = 0;
    int       dr_mode = 0;
    bit       gap_en = 1'b0;
    bit       dr_tog = 1'b0;

    always @(posedge clk) begin
        #1;
        bus.blk_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'($urandom_range(1)) : 1'b0;
        dr_tog = ~dr_tog;
        bus.d_ready = dr_mode == 0 ? 1'b1 : dr_mode == 1 ? 1'($urandom_range(1)) : dr_tog;
    end

    always @(negedge clk) begin
        if (bus.blk_valid && bus.blk_ready) blk_q.push_back('{bus.blk_m, bus.blk_t, bus.blk_f});
        if (bus.d_valid && bus.d_ready) dig_q.push_back({bus.d_last, bus.d_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic int nblk_of(int len);
        return len == 0 ? 1 : (len + BB - 1) / BB;
    endfunction

    function automatic int eff_len(int ol);
        return (ol == 0 || ol > W) ? W : ol;
    endfunction

    function automatic blk_rec_t model_blk(input bq_t msg, input int b);
        blk_rec_t r;
        int n = msg.size();
        r.m = '0;
        for (int i = 0; i < BB; i++)
            if (b * BB + i < n) r.m[8*i +: 8] = msg[b*BB+i];
        r.t = 64'((b + 1) * BB < n ? (b + 1) * BB : n);
        r.f = (b == nblk_of(n) - 1);
        return r;
    endfunction

    task automatic do_start(input int ol);
        bus.start = 1'b1;
        bus.out_len = 6'(ol);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input bq_t msg);
        int n = msg.size();
        int pos = 0;
        int budget = 5000;
        bit done = 1'b0;
        while (!done) begin
            int nb = (n - pos > IB) ? IB : n - pos;
            bus.s_valid = gap_en ? 1'($urandom_range(1)) : 1'b1;
            bus.s_data = $urandom;
            for (int k = 0; k < nb; k++) bus.s_data[8*k +: 8] = msg[pos+k];
            bus.s_nbytes = 3'(nb);
            bus.s_last = (pos + nb == n);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin
                pos += nb;
                done = (pos == n);
            end
            @(posedge clk); #1;
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 32'(budget), 1);
                done = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
    endtask

    task automatic wait_blk(input int n);
        int c = 0;
        while (blk_q.size() < n && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("blk_wait", 32'(blk_q.size() >= n), 1);
    endtask

    task automatic run_msg(input string nm, input bq_t msg, input int ol, input logic [255:0] h);
        int nb = nblk_of(msg.size());
        int el = eff_len(ol);
        int c = 0;
        blk_q.delete();
        dig_q.delete();
        do_start(ol);
        send(msg);
        wait_blk(nb);
        repeat (8) @(posedge clk);
        #1;
        chk({nm, " nblk"}, blk_q.size(), nb);
        for (int b = 0; b < nb && b < blk_q.size(); b++) begin
            blk_rec_t e = model_blk(msg, b);
            chk($sformatf("%s blk%0d m", nm, b), blk_q[b].m, e.m);
            chk($sformatf("%s blk%0d t", nm, b), blk_q[b].t, e.t);
            chk($sformatf("%s blk%0d f", nm, b), blk_q[b].f, e.f);
        end
        repeat ($urandom_range(3)) @(posedge clk);
        #1;
        bus.h_in = h;
        bus.h_valid = 1'b1;
        @(posedge clk); #1;
        bus.h_valid = 1'b0;
        while (dig_q.size() < el && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({nm, " dlen"}, dig_q.size(), el);
        for (int j = 0; j < el && j < dig_q.size(); j++)
            chk($sformatf("%s d%0d", nm, j), dig_q[j], {j == el - 1, h[8*j +: 8]});
        chk({nm, " idle"}, {bus.d_valid, bus.d_last, bus.s_ready, bus.blk_valid}, 0);
    endtask

    initial begin
        bq_t      msg;
        bq_t      abc;
        logic [255:0] h;
        logic [255:0] hj;
        vec_t     vt[7];
        blk_rec_t eb;
        int       cnt;
        bus.start = 0; bus.out_len = 0; bus.s_data = 0; bus.s_nbytes = 0; bus.s_last = 0;
        bus.s_valid = 0; bus.h_in = 0; bus.h_valid = 0;
        abc = '{8'h61, 8'h62, 8'h63};
        for (int j = 0; j < 32; j++) hj[8*j +: 8] = 8'(j);
        vt[0] = '{0,   20, 1, 0,   20};
        vt[1] = '{64,  0,  1, 64,  32};
        vt[2] = '{65,  33, 2, 65,  32};
        vt[3] = '{128, 1,  2, 128, 1};
        vt[4] = '{129, 32, 3, 129, 32};
        vt[5] = '{7,   5,  1, 7,   5};
        vt[6] = '{63,  16, 1, 63,  16};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset ctl", {bus.s_ready, bus.blk_valid, bus.blk_f, bus.d_valid, bus.d_last}, 0);
        chk("reset blk_m", bus.blk_m, 0);
        chk("reset blk_t", bus.blk_t, 0);
        chk("reset d_data", bus.d_data, 0);
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            msg.delete();
            for (int i = 0; i < vt[v].len; i++) msg.push_back(8'(i * 7 + vt[v].len));
            for (int j = 0; j < 8; j++) h[32*j +: 32] = $urandom;
            run_msg($sformatf("vec%0d", v), msg, vt[v].out_len, h);
            chk($sformatf("vec%0d tbl nblk", v), blk_q.size(), vt[v].exp_nblk);
            if (blk_q.size() > 0) chk($sformatf("vec%0d tbl t", v), blk_q[blk_q.size()-1].t, vt[v].exp_t);
            chk($sformatf("vec%0d tbl dlen", v), dig_q.size(), vt[v].exp_dlen);
        end

        run_msg("abc", abc, 32, hj);
        if (blk_q.size() > 0) chk("abc m", blk_q[0].m, 512'h636261);

        dr_mode = 2;
        run_msg("dig20", abc, 20, hj);
        dr_mode = 0;

        bp_mode = 2;
        blk_q.delete();
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(8'hA0 + i));
        do_start(32);
        send(msg);
        eb = model_blk(msg, 0);
        bus.s_valid = 1'b1; bus.s_data = 32'hDEADBEEF; bus.s_nbytes = 3'd4; bus.s_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d valid", c), bus.blk_valid, 1);
            chk($sformatf("bp%0d m", c), bus.blk_m, eb.m);
            chk($sformatf("bp%0d t", c), bus.blk_t, eb.t);
            chk($sformatf("bp%0d f", c), bus.blk_f, eb.f);
            chk($sformatf("bp%0d s_ready", c), bus.s_ready, 0);
            @(posedge clk); #1;
        end
        bp_mode = 0;
        wait_blk(1);
        repeat (4) @(posedge clk);
        #1;
        chk("bp handshakes", blk_q.size(), 1);
        chk("bp beat held", bus.s_ready, 0);
        bus.s_valid = 1'b0;

        blk_q.delete();
        do_start(20);
        send(abc);
        wait_blk(1);
        bus.h_in = hj;
        bus.h_valid = 1'b1;
        @(posedge clk); #1;
        bus.h_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 6; c++) begin
            @(negedge clk);
            if (bus.d_valid && bus.d_ready) cnt++;
        end
        chk("abort bytes", cnt, 6);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.out_len = 6'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort d_valid", bus.d_valid, 0);
        chk("abort s_ready", bus.s_ready, 1);
        @(posedge clk); #1;

        blk_q.delete();
        do_start(32);
        bus.s_valid = 1'b1; bus.s_data = 32'h11223344; bus.s_nbytes = 3'd4; bus.s_last = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst ctl", {bus.s_ready, bus.blk_valid, bus.blk_f, bus.d_valid, bus.d_last}, 0);
        chk("rst blk_m", bus.blk_m, 0);
        chk("rst blk_t", bus.blk_t, 0);
        chk("rst d_data", bus.d_data, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst no block", blk_q.size(), 0);

        for (int r = 0; r < 10; r++) begin
            int len = $urandom_range(200);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            for (int j = 0; j < 8; j++) h[32*j +: 32] = $urandom;
            bp_mode = $urandom_range(1);
            dr_mode = $urandom_range(2);
            gap_en = 1'($urandom_range(1));
            run_msg($sformatf("rnd%0d", r), msg, $urandom_range(63), h);
        end
        bp_mode = 0;
        dr_mode = 0;
        gap_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/blake2_stream_pack.md
# blake2_stream_pack

Parametrised BLAKE2 message packer and digest serializer. Sits between a byte-stream source and the BLAKE2 compression core. Packs multi-byte input beats little-endian into 16-word message blocks with correct byte counter and final-block flag, and handles core backpressure and the empty message. Streams a runtime-selectable number of digest bytes back out under a ready/valid handshake.

## Interface
- W, 32, word width in bits: 32 = BLAKE2s, 64 = BLAKE2b. Block size BB = 2*W bytes.
- IN_BYTES, 4, bytes per input beat. Power of two, 1..8, and must divide BB.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new message; samples out_len.
- out_len  in  $clog2(W)+1  digest length in bytes; 0 or >W is treated as W.
- s_data  in  8*IN_BYTES  input bytes; byte k = s_data[8k+:8], k=0 first.
- s_nbytes  in  $clog2(IN_BYTES)+1  valid bytes in beat, taken from k=0 up.
- s_last  in  1  beat carries the final message byte.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- blk_m  out  16*W  message block; message byte i of block = blk_m[8i+:8].
- blk_t  out  2*W  byte counter; t0 = blk_t[W-1:0], t1 = blk_t[2W-1:W].
- blk_f  out  1  final-block flag.
- blk_valid  out  1  block valid.
- blk_ready  in  1  core accepts block.
- h_in  in  8*W  chaining value after the final block; byte j = h_in[8j+:8].
- h_valid  in  1  one-cycle pulse, h_in valid.
- d_data  out  8  digest byte.
- d_valid  out  1  digest byte valid.
- d_ready  in  1  sink accepts byte.
- d_last  out  1  marks digest byte out_len-1.

## Operation
- States: IDLE, FILL, EMIT, WAIT_H, OUT.
- IDLE: all ready/valid outputs are low.
- start, any state except reset:
  - clear the buffer, byte index and t;
  - latch the effective out_len;
  - enter FILL.
- start takes priority over every other event and aborts a block or digest in flight.
- FILL:
  - s_ready = 1.
  - An accepted beat writes s_nbytes bytes at byte index idx.
  - idx += s_nbytes, t += s_nbytes. t is 2W bits and wraps modulo 2^(2W).
- Input protocol:
  - s_nbytes < IN_BYTES is legal only with s_last.
  - s_nbytes = 0 is legal only with s_last, and only as the first beat of a message (empty message).
  - Because IN_BYTES divides BB, a beat never straddles two blocks.
- FILL -> EMIT when the accepted beat:
  - fills the block (idx reaches BB): f = s_last;
  - or carries s_last: f = 1, unused bytes stay zero.
- Empty message: one all-zero block with t = 0, f = 1.
- A message of exactly k*BB bytes produces exactly k blocks. No trailing empty block is sent.
- EMIT:
  - blk_valid = 1;
  - blk_m, blk_t and blk_f are held stable until blk_ready;
  - s_ready = 0.
- On the EMIT handshake, clear the buffer and idx, then:
  - to FILL if f = 0;
  - to WAIT_H if f = 1.
- WAIT_H: h_valid latches h_in and loads the byte counter with out_len; go to OUT. h_valid in any other state is ignored.
- OUT:
  - d_valid = 1, d_data = current byte, starting at h byte 0.
  - Each d_ready handshake advances one byte.
  - d_last accompanies the byte at index out_len-1.
  - Go to IDLE on the d_last handshake.

## Timing
- Reset values: s_ready, blk_valid, blk_f, d_valid and d_last are 0; blk_m, blk_t and d_data are 0; state IDLE.
- The cycle after start, s_ready = 1.
- Block-completing beat accepted in cycle N -> blk_valid = 1 in cycle N+1, with s_ready = 0 in N+1.
- Blk handshake in cycle N:
  - s_ready = 1 in N+1 (non-final);
  - otherwise WAIT_H in N+1.
- Two consecutive blocks are therefore spaced at least BB/IN_BYTES + 1 cycles apart.
- h_valid in cycle N -> d_valid = 1 with byte 0 in N+1. Throughput is one byte per cycle while d_ready = 1.
- All outputs are registered, with no combinational input-to-output paths.
- rst mid-message: everything returns to reset values the next cycle, and no partial block is emitted.

## Structure
- Package blake2_pkg:
  - state enum;
  - BB and index-width constants as functions of W;
  - IN_BYTES legality check, an elaboration-time assertion.
- Sub-module blake2_digest_ser:
  - holds the h register, byte counter, d_valid/d_last logic;
  - inputs are load, len and h; it outputs a done pulse to the top FSM.
- The top holds the packing FSM, block buffer and t.

## Test plan
- W=32, IN_BYTES=4, empty message: start, then a beat with s_nbytes=0 and s_last -> one block, blk_m=0, blk_t=0, blk_f=1.
- "abc": one beat s_data=0x00636261, s_nbytes=3, s_last -> blk_m[23:0]=0x636261, rest 0, blk_t=3, blk_f=1.
- 64 bytes, 16 full beats with s_last on the 16th -> exactly one block, t=64, f=1, and no second block.
- 65 bytes -> block1 t=64, f=0; block2 t=65, f=1, blk_m[7:0]=byte 64, rest 0.
- Hold blk_ready low for 5 cycles -> blk_valid, blk_m, blk_t and blk_f stable; s_ready=0 throughout; s_valid beats not consumed.
- out_len=20, h_valid with h_in byte j = j, d_ready toggling each cycle:
  - 20 bytes 0x00..0x13 are delivered;
  - d_last on 0x13, then IDLE.
  - Repeat with start asserted after byte 5 -> d_valid drops the next cycle and s_ready=1.
